// File: rtl/proc_param_mc_if.sv
// Bus bundle between proc_param_mc and its system controller / memory.
// The master modport is the core's view; the slave modport is the environment's.
interface proc_param_mc_if #(
    parameter int unsigned DW = 9
);
    logic          run;
    logic [DW-1:0] din;
    logic          mem_ready;
    logic [DW-1:0] addr;
    logic [DW-1:0] dout;
    logic          wen;
    logic          done;
    logic          busy;

    modport master (
        input  run, din, mem_ready,
        output addr, dout, wen, done, busy
    );

    modport slave (
        output run, din, mem_ready,
        input  addr, dout, wen, done, busy
    );
endinterface

// File: rtl/proc_param_mc.sv
// Parameterised multicycle processor: 8 registers (R7 = PC), A/G ALU registers,
// ready-handshaked single-port memory, run-controlled continuous execution.
module proc_param_mc #(
    parameter int unsigned    DW       = 9,
    parameter logic [DW-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    proc_param_mc_if.master bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_F_ADDR = 3'd1;
    localparam logic [2:0] S_F_WAIT = 3'd2;
    localparam logic [2:0] S_E1     = 3'd3;
    localparam logic [2:0] S_E2     = 3'd4;
    localparam logic [2:0] S_E3     = 3'd5;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_LD   = 3'b100;
    localparam logic [2:0] OP_ST   = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;
    localparam logic [2:0] OP_AND  = 3'b111;

    logic [2:0]    state_q, state_d;
    logic [DW-1:0] regs_q [8];
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] g_q, g_d;
    logic [8:0]    ir_q, ir_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          done_q;

    logic [2:0]    op, rx, ry;
    logic [DW-1:0] pc, rx_val, ry_val, alu;
    logic          rf_we, pc_inc, complete;
    logic [DW-1:0] rf_wd;

    assign op     = ir_q[8:6];
    assign rx     = ir_q[5:3];
    assign ry     = ir_q[2:0];
    assign pc     = regs_q[7];
    assign rx_val = regs_q[rx];
    assign ry_val = regs_q[ry];

    always_comb begin
        unique case (op)
            OP_ADD:  alu = a_q + ry_val;
            OP_SUB:  alu = a_q - ry_val;
            default: alu = a_q & ry_val;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        a_d      = a_q;
        g_d      = g_q;
        addr_d   = addr_q;
        dout_d   = dout_q;
        rf_we    = 1'b0;
        rf_wd    = '0;
        pc_inc   = 1'b0;
        complete = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.run) state_d = S_F_ADDR;
            end
            S_F_ADDR: begin
                addr_d  = pc;
                state_d = S_F_WAIT;
            end
            S_F_WAIT: begin
                if (bus.mem_ready) begin
                    ir_d    = bus.din[8:0];
                    pc_inc  = 1'b1;
                    state_d = S_E1;
                end
            end
            S_E1: begin
                state_d = S_E2;
                case (op)
                    OP_MV: begin
                        rf_we    = 1'b1;
                        rf_wd    = ry_val;
                        complete = 1'b1;
                    end
                    OP_MVNZ: begin
                        rf_we    = (g_q != '0);
                        rf_wd    = ry_val;
                        complete = 1'b1;
                    end
                    OP_MVI: addr_d = pc;
                    OP_LD:  addr_d = ry_val;
                    OP_ST: begin
                        addr_d = ry_val;
                        dout_d = rx_val;
                    end
                    default: a_d = rx_val;
                endcase
            end
            S_E2: begin
                case (op)
                    OP_MVI: begin
                        if (bus.mem_ready) begin
                            rf_we    = 1'b1;
                            rf_wd    = bus.din;
                            pc_inc   = 1'b1;
                            complete = 1'b1;
                        end
                    end
                    OP_LD: begin
                        if (bus.mem_ready) begin
                            rf_we    = 1'b1;
                            rf_wd    = bus.din;
                            complete = 1'b1;
                        end
                    end
                    OP_ST: begin
                        complete = bus.mem_ready;
                    end
                    default: begin
                        g_d     = alu;
                        state_d = S_E3;
                    end
                endcase
            end
            S_E3: begin
                rf_we    = 1'b1;
                rf_wd    = g_q;
                complete = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (complete) state_d = bus.run ? S_F_ADDR : S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            for (int unsigned i = 0; i < 7; i++) regs_q[i[2:0]] <= '0;
            regs_q[7] <= RESET_PC;
            a_q     <= '0;
            g_q     <= '0;
            ir_q    <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            g_q     <= g_d;
            ir_q    <= ir_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            done_q  <= complete;
            // Increment first so a same-cycle register write to R7 overrides it.
            if (pc_inc) regs_q[7] <= pc + DW'(1);
            if (rf_we) regs_q[rx] <= rf_wd;
        end
    end

    assign bus.addr = addr_q;
    assign bus.dout = dout_q;
    assign bus.wen  = (state_q == S_E2) && (op == OP_ST);
    assign bus.done = done_q;
    assign bus.busy = (state_q != S_IDLE);
endmodule
